// File: rtl/ripple_seq_ctrl.sv
// rtl/ripple_seq_ctrl.sv - byte-serial wide adder around one shared ripple_8 slice
// Optional subtract mode: define RIPPLE_SEQ_SUB_EN to add the sub port.

module ripple_8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = in1[i] ^ in2[i] ^ w_c[i];
        assign w_c[i+1] = (in1[i] & in2[i]) | (w_c[i] & (in1[i] ^ in2[i]));
    end

    assign cout = w_c[8];
endmodule

module ripple_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
`ifdef RIPPLE_SEQ_SUB_EN
    input  logic                sub,
`endif
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                busy
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_result;
    logic           r_carry;
    logic           r_cout;
    logic [CW-1:0]  r_cnt;
    logic           w_last;
    logic [7:0]     w_b_byte;
    logic [7:0]     w_sum;
    logic           w_cout;
    logic           w_init_carry;

`ifdef RIPPLE_SEQ_SUB_EN
    logic r_sub;

    // Subtraction is A + ~B + 1, so the carry chain is seeded with 1.
    assign w_b_byte     = r_b[7:0] ^ {8{r_sub}};
    assign w_init_carry = sub ? 1'b1 : cin;
`else
    assign w_b_byte     = r_b[7:0];
    assign w_init_carry = cin;
`endif

    assign w_last = (r_cnt == CW'(NBYTES - 1));

    ripple_8 u_ripple_8 (
        .in1  (r_a[7:0]),
        .in2  (w_b_byte),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_valid) w_next = S_RUN;
            S_RUN:   if (w_last)      w_next = S_DONE;
            S_DONE:  if (res_ready)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE:  start_ready = 1'b1;
            S_RUN:   busy        = 1'b1;
            S_DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
`ifdef RIPPLE_SEQ_SUB_EN
            r_sub    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_carry <= w_init_carry;
                        r_cnt   <= '0;
`ifdef RIPPLE_SEQ_SUB_EN
                        r_sub   <= sub;
`endif
                    end
                end
                S_RUN: begin
                    // Sum bytes enter at the top so byte 0 lands at the bottom after NBYTES shifts.
                    r_result <= {w_sum, r_result[W-1:8]};
                    r_carry  <= w_cout;
                    r_a      <= {8'h00, r_a[W-1:8]};
                    r_b      <= {8'h00, r_b[W-1:8]};
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
endmodule

// File: tb/tb_ripple_seq_ctrl.sv
// tb/tb_ripple_seq_ctrl.sv - scoreboard bench for ripple_seq_ctrl
module tb_ripple_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cin;
    logic        sub_i;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        cout;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    ripple_seq_ctrl #(.NBYTES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef RIPPLE_SEQ_SUB_EN
        .sub         (sub_i),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every result handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("result_cout", {31'd0, cout, result}, {31'd0, e});
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input logic [32:0] exp, output int edges);
        int k;
        edges = -1;
        k = 0;
        while (!start_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!start_ready) chk("wait_start_ready_timeout", 64'd0, 64'd1);
        sb.push_back(exp);
        op_a = a; op_b = b; cin = c; sub_i = s;
        start_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 1) start_valid = 1'b0;
            if (res_valid) begin
                edges = n;
                break;
            end
        end
        if (edges < 0) chk("res_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges;
        int n;
        rst = 1'b1; start_valid = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        sub_i = 1'b0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_start_ready", {63'd0, start_ready}, 64'd1);
        chk("rst_res_valid",   {63'd0, res_valid},   64'd0);
        chk("rst_busy",        {63'd0, busy},        64'd0);
        chk("rst_result",      {32'd0, result},      64'd0);
        chk("rst_cout",        {63'd0, cout},        64'd0);

        // 0xFF + 1 with latency measurement
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 32'h00000100}, edges);
        chk("latency_edges", edges, 64'd5);
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        chk("res_valid_one_cycle", {63'd0, res_valid}, 64'd0);
        chk("start_ready_back", {63'd0, start_ready}, 64'd1);

        // Carry through every slice
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b1, 32'h00000000}, edges);
        @(posedge clk); #1;

        // Back-pressure: result must hold and a new request must be ignored
        res_ready = 1'b0;
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, {1'b0, 32'h23456789}, edges);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin
                op_a = 32'hDEADBEEF; op_b = 32'h01020304; cin = 1'b1; start_valid = 1'b1;
            end
            if (i == 3) start_valid = 1'b0;
            chk("hold_result", {32'd0, result}, {32'd0, 32'h23456789});
            chk("hold_cout", {63'd0, cout}, 64'd0);
            chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_start_ready", {63'd0, start_ready}, 64'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release_valid", {63'd0, res_valid}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("ignored_req_idle", {63'd0, busy}, 64'd0);
        end

        // Reset during the second RUN cycle
        op_a = 32'hAAAAAAAA; op_b = 32'h55555555; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_rst_start_ready", {63'd0, start_ready}, 64'd1);
        chk("midrun_rst_res_valid",   {63'd0, res_valid},   64'd0);
        chk("midrun_rst_busy",        {63'd0, busy},        64'd0);
        chk("midrun_rst_result",      {32'd0, result},      64'd0);
        chk("midrun_rst_cout",        {63'd0, cout},        64'd0);
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (res_valid) n++;
        end
        chk("no_result_after_rst", n, 64'd0);

        // Back-to-back with start_valid and res_ready held high
        sb.push_back({1'b0, 32'h00000003});
        sb.push_back({1'b1, 32'h00000000});
        op_a = 32'h1; op_b = 32'h2; cin = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 32'h80000000; op_b = 32'h80000000;
        n = 0;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_spacing", n + 1, 64'd6);
        @(posedge clk); #1;
        start_valid = 1'b0;
        chk("b2b_second_accept_busy", {63'd0, busy}, 64'd1);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_latency", n + 1, 64'd5);
        @(posedge clk); #1;

`ifdef RIPPLE_SEQ_SUB_EN
        run_op(32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 32'hFFFFFFFE}, edges);
        @(posedge clk); #1;
        run_op(32'd7, 32'd5, 1'b0, 1'b1, {1'b1, 32'h00000002}, edges);
        @(posedge clk); #1;
        run_op(32'd7, 32'd5, 1'b0, 1'b0, {1'b0, 32'h0000000C}, edges);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
